// File: rtl/defuzz_centroid.sv
// Centroid defuzzifier: accumulates sum(mu*s) and sum(mu) per frame, then divides with a
// 9-bit restoring divider. Optional macro DEFUZZ_ROUND_EN rounds instead of truncating.
module defuzz_centroid #(
  parameter int MAX_TERMS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [15:0] in_mu,
  input  logic [7:0] in_s,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic       out_zero,
  output logic       out_ovf
);
  localparam int LG = $clog2(MAX_TERMS);
  localparam int NW = 24 + LG;
  localparam int DW = 15 + LG;
  localparam int RW = NW + 1;

  typedef enum logic [1:0] {ACC, DIV, DONE} state_t;
  state_t state_q, state_d;

  logic signed [NW-1:0] num_q;
  logic [DW-1:0]        den_q;
  logic [LG:0]          cnt_q;
  logic                 ovf_q;
  logic [3:0]           step_q;
  logic [RW-1:0]        rem_q, dsh_q;
  logic [7:0]           q_q;
  logic [7:0]           y_q;
  logic                 zero_q;

  logic                 accept;
  logic signed [23:0]   mu_x, s_x, prod;
  logic [NW-1:0]        num_u, num_abs;
  logic                 ge;
  logic [RW-1:0]        rem_nx;
  logic [8:0]           q9, mag_r;
  logic [7:0]           y_fin;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_y     = y_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid && in_ready;

  // Product of Q1.15 and Q7.0 always fits 24 signed bits
  assign mu_x = {8'd0, in_mu};
  assign s_x  = {{16{in_s[7]}}, in_s};
  assign prod = mu_x * s_x;

  assign num_u   = num_q;
  assign num_abs = num_u[NW-1] ? (~num_u + {{(NW-1){1'b0}}, 1'b1}) : num_u;

  assign ge     = (rem_q >= dsh_q);
  assign rem_nx = ge ? (rem_q - dsh_q) : rem_q;
  assign q9     = {q_q, ge};

`ifdef DEFUZZ_ROUND_EN
  assign mag_r = {1'b0, q9[8:1]} + {8'd0, q9[0]};
`else
  assign mag_r = {1'b0, q9[8:1]};
`endif

  always_comb begin
    y_fin = 8'd0;
    if (den_q == '0)              y_fin = 8'd0;
    else if (num_u[NW-1]) begin
      if (mag_r >= 9'd128)        y_fin = 8'h80;
      else                        y_fin = ~mag_r[7:0] + 8'd1;
    end else if (mag_r > 9'd127)  y_fin = 8'h7F;
    else                          y_fin = mag_r[7:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && in_last) state_d = DIV;
      DIV:     if (step_q == 4'd9)    state_d = DONE;
      DONE:    if (out_ready)         state_d = ACC;
      default:                        state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      dsh_q  <= '0;
      q_q    <= '0;
      y_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          step_q <= '0;
          if (accept) begin
            // Beats past MAX_TERMS are consumed but only flag overflow
            if (cnt_q == (LG+1)'(MAX_TERMS)) ovf_q <= 1'b1;
            else begin
              num_q <= num_q + {{LG{prod[23]}}, prod};
              den_q <= den_q + {{LG{1'b0}}, in_mu[14:0]};
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DIV: begin
          step_q <= step_q + 4'd1;
          if (step_q == 4'd0) begin
            // Dividend carries one fraction bit; divisor starts at weight 2^8
            rem_q <= {num_abs, 1'b0};
            dsh_q <= {2'b00, den_q, 8'd0};
            q_q   <= '0;
          end else begin
            rem_q <= rem_nx;
            dsh_q <= dsh_q >> 1;
            q_q   <= {q_q[6:0], ge};
            if (step_q == 4'd9) begin
              y_q    <= y_fin;
              zero_q <= (den_q == '0);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            num_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            y_q    <= '0;
            zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/defuzz_centroid.md
DEFUZZ_CENTROID -- requirements
Module: defuzz_centroid

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 16, meaning the maximum rule terms accumulated per frame (power of 2, 2..64).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  term beat valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a term beat.
REQ-006 SHALL have port in_mu  input  16  rule strength μ, unsigned Q1.15, 0..0x7FFF.
REQ-007 SHALL have port in_s  input  8  output singleton position, signed Q7.0.
REQ-008 SHALL have port in_last  input  1  final term of the frame.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out_y  output  8  crisp output, signed Q7.0.
REQ-012 SHALL have port out_zero  output  1  Σμ was 0; out_y forced to 0.
REQ-013 SHALL have port out_ovf  output  1  frame exceeded MAX_TERMS beats.

Function
REQ-014 SHALL compute out_y = Σ(μi·si) / Σμi over all beats of a frame (centroid of singletons).
REQ-015 SHALL implement three states: ACC (in_ready=1), DIV (in_ready=0), DONE (out_valid=1, in_ready=0).
REQ-016 SHALL accept a beat on every edge where in_valid && in_ready; accepted μ·s is added to a signed numerator accumulator and μ to an unsigned denominator accumulator.
REQ-017 SHALL size the accumulators lossless: numerator 24+log2(MAX_TERMS) bits signed, denominator 15+log2(MAX_TERMS) bits unsigned; no wrap-around permitted.
REQ-018 SHALL ignore μ/s of beats beyond the MAX_TERMS-th in a frame, still accept them, and set out_ovf for that frame.
REQ-019 SHALL transition ACC->DIV on the edge accepting a beat with in_last=1.
REQ-020 SHALL remain in DIV exactly 10 cycles: 1 sign/magnitude setup cycle, then a restoring divider producing 1 quotient bit per cycle (8 integer bits + 1 fraction bit), MSB first.
REQ-021 SHALL assert out_valid on the 10th edge after the edge accepting in_last (fixed latency, including the Σμ=0 case).
REQ-022 SHALL, when Σμ=0, produce out_y=0 and out_zero=1 without division by zero.
REQ-023 SHALL apply the numerator sign to the magnitude quotient and saturate to -128..127.
REQ-024 SHALL hold out_y, out_zero, out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on an edge with out_valid && out_ready, deassert out_valid, clear the accumulators, term counter and flags, and enter ACC; in_ready rises in the following cycle.
REQ-026 SHALL ignore in_valid while in DIV or DONE.
REQ-027 SHALL treat a frame of a single beat (in_last on the first beat) as a normal frame.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state ACC, in_ready=1, out_valid=0, out_y=0, out_zero=0, out_ovf=0, and clear the accumulators, term counter and divider registers.
REQ-029 SHALL abandon any frame or division in progress when reset is asserted; no result for that frame is ever presented.

Configuration
REQ-030 SHALL, with macro DEFUZZ_ROUND_EN defined, round the quotient magnitude half-away-from-zero using the fraction bit before sign application and saturation.
REQ-031 SHALL, without DEFUZZ_ROUND_EN, truncate toward zero (fraction bit discarded); latency remains 10 cycles in both builds.

Verification
REQ-032 SHALL cover: beats (0x7FFF,40), (0x7FFF,-20,last) -> out_y=10, out_zero=0, out_valid 10 cycles after the last beat.
REQ-033 SHALL cover: beats (0x7FFF,1), (0x7FFF,2,last) -> out_y=2 with DEFUZZ_ROUND_EN, out_y=1 without.
REQ-034 SHALL cover: single beat (0x4000,-128,last) -> out_y=-128; beats (0,5),(0,7,last) -> out_y=0, out_zero=1.
REQ-035 SHALL cover: out_ready held low 5 cycles in DONE -> out_y stable, in_ready=0, extra in_valid ignored; result consumed on the 6th cycle.
REQ-036 SHALL cover: 17 beats with MAX_TERMS=16 -> out_ovf=1; rst_n pulsed low mid-DIV -> out_valid never rises, next frame computes correctly.
